// File: rtl/x_therm_pkg.sv
// rtl/x_therm_pkg.sv - shared types and edge-creep index mapping for the unary element driver
package x_therm_pkg;

    typedef enum logic {MODE_STATIC, MODE_DWA} mode_e;

    // Even thermometer bits fill from element 0 upward, odd bits from element n-1 downward.
    function automatic int unsigned creep_idx(input int unsigned i, input int unsigned n);
        return (i % 2 == 0) ? (i / 2) : (n - 1 - i / 2);
    endfunction

endpackage

// File: rtl/x_therm_dwa_if.sv
// rtl/x_therm_dwa_if.sv - sample/enable bus between modulator and unary element driver
interface x_therm_dwa_if
    import x_therm_pkg::*;
#(
    parameter int N = 64
);
    localparam int PW = $clog2(N);
    localparam int BW = PW + 1;

    logic          i_vld;
    logic [BW-1:0] i_bin;
    mode_e         i_mode;
    logic          i_ptr_clr;
    logic          o_vld;
    logic [N-1:0]  o_therm;
    logic          o_sat;
    logic [PW-1:0] o_ptr;

    modport master (
        output i_vld, i_bin, i_mode, i_ptr_clr,
        input  o_vld, o_therm, o_sat, o_ptr
    );

    modport slave (
        input  i_vld, i_bin, i_mode, i_ptr_clr,
        output o_vld, o_therm, o_sat, o_ptr
    );

endinterface

// File: rtl/x_therm_rot.sv
// rtl/x_therm_rot.sv - k-element thermometer circularly rotated to start at element p
module x_therm_rot #(
    parameter int N = 64,
    localparam int PW = $clog2(N),
    localparam int BW = PW + 1
) (
    input  logic [BW-1:0] k,
    input  logic [PW-1:0] p,
    output logic [N-1:0]  en
);

    logic [N-1:0]   therm;
    logic [2*N-1:0] wide;

    always_comb begin
        therm = '0;
        for (int i = 0; i < N; i++) begin
            therm[i] = (k > BW'(i));
        end
        // Bits shifted past the top of the array fold back onto the bottom.
        wide = {{N{1'b0}}, therm} << p;
        en   = wide[N-1:0] | wide[2*N-1:N];
    end

endmodule

// File: rtl/x_therm_dwa.sv
// rtl/x_therm_dwa.sv - two-stage binary to unary element driver with edge-creep and DWA ordering
module x_therm_dwa
    import x_therm_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         i_clk,
    input  logic         i_nrst,
    x_therm_dwa_if.slave bus
);

    localparam int PW = $clog2(N);
    localparam int BW = PW + 1;

    logic          s1_vld;
    logic [BW-1:0] s1_k;
    logic          s1_sat;
    mode_e         s1_mode;
    logic [PW-1:0] s1_p;
    logic [PW-1:0] ptr;

    logic          in_sat;
    logic [BW-1:0] in_k;
    logic [PW-1:0] p_snap;
    logic [BW-1:0] ptr_sum;
    logic [BW-1:0] ptr_wrap;
    logic [N-1:0]  stat_en;
    logic [N-1:0]  dwa_en;

    always_comb begin
        in_sat   = bus.i_bin > BW'(N);
        in_k     = in_sat ? BW'(N) : bus.i_bin;
        // A clear on the same cycle as a sample makes that sample start from element 0.
        p_snap   = bus.i_ptr_clr ? '0 : ptr;
        ptr_sum  = BW'(p_snap) + in_k;
        ptr_wrap = (ptr_sum >= BW'(N)) ? (ptr_sum - BW'(N)) : ptr_sum;
    end

    for (genvar i = 0; i < N; i++) begin : g_creep
        assign stat_en[creep_idx(i, N)] = (s1_k > BW'(i));
    end

    x_therm_rot #(.N(N)) u_rot (
        .k  (s1_k),
        .p  (s1_p),
        .en (dwa_en)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            s1_vld      <= 1'b0;
            s1_k        <= '0;
            s1_sat      <= 1'b0;
            s1_mode     <= MODE_STATIC;
            s1_p        <= '0;
            ptr         <= '0;
            bus.o_vld   <= 1'b0;
            bus.o_therm <= '0;
            bus.o_sat   <= 1'b0;
        end else begin
            s1_vld <= bus.i_vld;
            if (bus.i_vld) begin
                s1_k    <= in_k;
                s1_sat  <= in_sat;
                s1_mode <= bus.i_mode;
                s1_p    <= p_snap;
                ptr     <= (bus.i_mode == MODE_DWA) ? PW'(ptr_wrap) : p_snap;
            end else if (bus.i_ptr_clr) begin
                ptr <= '0;
            end

            // Without a new sample the DAC level is held.
            bus.o_vld <= s1_vld;
            if (s1_vld) begin
                bus.o_therm <= (s1_mode == MODE_DWA) ? dwa_en : stat_en;
                bus.o_sat   <= s1_sat;
            end
        end
    end

    assign bus.o_ptr = ptr;

endmodule

// File: tb/tb_x_therm_dwa.sv
// tb/tb_x_therm_dwa.sv - directed self-checking bench for x_therm_dwa at N=8
module tb_x_therm_dwa;
    import x_therm_pkg::*;

    localparam int N = 8;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    x_therm_dwa_if #(.N(N)) bus ();

    x_therm_dwa #(.N(N)) dut (
        .i_clk  (clk),
        .i_nrst (nrst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic single(input string tag, input logic [3:0] bin, input mode_e mode,
                          input logic clr, input logic [7:0] et, input logic es,
                          input logic [2:0] ep);
        @(negedge clk);
        bus.i_vld = 1'b1; bus.i_bin = bin; bus.i_mode = mode; bus.i_ptr_clr = clr;
        @(negedge clk);
        bus.i_vld = 1'b0; bus.i_ptr_clr = 1'b0;
        chk({tag, "_ptr"}, 32'(bus.o_ptr), 32'(ep));
        chk({tag, "_vld_early"}, 32'(bus.o_vld), 0);
        @(negedge clk);
        chk({tag, "_therm"}, 32'(bus.o_therm), 32'(et));
        chk({tag, "_sat"}, 32'(bus.o_sat), 32'(es));
        chk({tag, "_vld"}, 32'(bus.o_vld), 1);
        @(negedge clk);
        chk({tag, "_vld_fall"}, 32'(bus.o_vld), 0);
        chk({tag, "_hold"}, 32'(bus.o_therm), 32'(et));
    endtask

    initial begin
        bus.i_vld = 1'b0; bus.i_bin = '0; bus.i_mode = MODE_STATIC; bus.i_ptr_clr = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_therm", 32'(bus.o_therm), 0);
        chk("rst_vld", 32'(bus.o_vld), 0);
        chk("rst_sat", 32'(bus.o_sat), 0);
        chk("rst_ptr", 32'(bus.o_ptr), 0);
        nrst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("idle_therm", 32'(bus.o_therm), 0);
            chk("idle_vld", 32'(bus.o_vld), 0);
            chk("idle_ptr", 32'(bus.o_ptr), 0);
        end

        single("st3", 4'd3, MODE_STATIC, 1'b0, 8'h83, 1'b0, 3'd0);
        single("st8", 4'd8, MODE_STATIC, 1'b0, 8'hFF, 1'b0, 3'd0);
        single("st0", 4'd0, MODE_STATIC, 1'b0, 8'h00, 1'b0, 3'd0);

        // DWA burst 3,3,3 back to back
        @(negedge clk);
        bus.i_vld = 1'b1; bus.i_bin = 4'd3; bus.i_mode = MODE_DWA;
        @(negedge clk);
        chk("burst_ptr0", 32'(bus.o_ptr), 3);
        chk("burst_vld0", 32'(bus.o_vld), 0);
        @(negedge clk);
        chk("burst_ptr1", 32'(bus.o_ptr), 6);
        chk("burst_therm0", 32'(bus.o_therm), 32'h07);
        chk("burst_vld1", 32'(bus.o_vld), 1);
        @(negedge clk);
        bus.i_vld = 1'b0;
        chk("burst_ptr2", 32'(bus.o_ptr), 1);
        chk("burst_therm1", 32'(bus.o_therm), 32'h38);
        chk("burst_vld2", 32'(bus.o_vld), 1);
        @(negedge clk);
        chk("burst_therm2", 32'(bus.o_therm), 32'hC1);
        chk("burst_vld3", 32'(bus.o_vld), 1);
        @(negedge clk);
        chk("burst_vld4", 32'(bus.o_vld), 0);
        chk("burst_hold", 32'(bus.o_therm), 32'hC1);

        single("sat12", 4'd12, MODE_DWA, 1'b0, 8'hFF, 1'b1, 3'd1);
        single("sat_off", 4'd2, MODE_DWA, 1'b0, 8'h06, 1'b0, 3'd3);
        single("to5", 4'd2, MODE_DWA, 1'b0, 8'h18, 1'b0, 3'd5);
        single("clr_col", 4'd2, MODE_DWA, 1'b1, 8'h03, 1'b0, 3'd2);
        single("clr_zero", 4'd0, MODE_DWA, 1'b1, 8'h00, 1'b0, 3'd0);
        single("ms_dwa5", 4'd5, MODE_DWA, 1'b0, 8'h1F, 1'b0, 3'd5);
        single("ms_st2", 4'd2, MODE_STATIC, 1'b0, 8'h81, 1'b0, 3'd5);
        single("ms_dwa4", 4'd4, MODE_DWA, 1'b0, 8'hE1, 1'b0, 3'd1);

        // Reset in the middle of a DWA burst
        @(negedge clk);
        bus.i_vld = 1'b1; bus.i_bin = 4'd3; bus.i_mode = MODE_DWA;
        repeat (2) @(negedge clk);
        chk("mid_pre_vld", 32'(bus.o_vld), 1);
        nrst = 1'b0;
        bus.i_vld = 1'b0;
        #1;
        chk("mid_therm", 32'(bus.o_therm), 0);
        chk("mid_vld", 32'(bus.o_vld), 0);
        chk("mid_sat", 32'(bus.o_sat), 0);
        chk("mid_ptr", 32'(bus.o_ptr), 0);
        @(negedge clk);
        nrst = 1'b1;
        single("post_rst", 4'd1, MODE_DWA, 1'b0, 8'h01, 1'b0, 3'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
